// File: rtl/cache_req_ctrl.sv
// Request sequencer for the K-way CLOCK cache: read-hit, read-miss fill, write-through.
// Optional CACHE_STATS_EN adds saturating hit/miss/timeout counters.
`timescale 1ns/1ps
module cache_req_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int LINE_WIDTH   = 32,
  parameter int FILL_TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [LINE_WIDTH-1:0] resp_data,
  output logic                  resp_hit,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [LINE_WIDTH-1:0] c_val,
  output logic                  c_read,
  output logic                  c_write,
  input  logic                  c_hit,
  input  logic [LINE_WIDTH-1:0] c_out_val,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [LINE_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses,
  output logic [31:0]           stat_timeouts
`endif
);

  localparam int HW = $clog2(FILL_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(FILL_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, RD_ISSUE, RD_CHECK, MEM_RD, MEM_WAIT, FILL, WR_CACHE, MEM_WR, RESP
  } state_t;

  state_t                state;
  logic [HW-1:0]         hold_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] line_buf;

  // Request and fill data holding registers (data only, no reset)
  always_ff @(posedge clock) begin
    if (state == IDLE && req_valid) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (state == MEM_WAIT && mem_rvalid)
      line_buf <= mem_rdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_hit      <= 1'b0;
      resp_err      <= 1'b0;
      c_addr        <= '0;
      c_val         <= '0;
      c_read        <= 1'b0;
      c_write       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      hold_cnt      <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            resp_hit  <= 1'b0;
            resp_err  <= 1'b0;
            c_addr    <= req_addr;
            if (req_write) begin
              state     <= WR_CACHE;
              c_write   <= 1'b1;
              c_val     <= req_wdata;
              resp_data <= req_wdata;
              hold_cnt  <= '0;
            end else begin
              state  <= RD_ISSUE;
              c_read <= 1'b1;
            end
          end
        end
        RD_ISSUE: begin
          c_read <= 1'b0;
          state  <= RD_CHECK;
        end
        RD_CHECK: begin
          if (c_hit) begin
            resp_data <= c_out_val;
            resp_hit  <= 1'b1;
            state     <= RESP;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b0;
            mem_addr      <= addr_q;
            state         <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_rvalid) begin
            c_write  <= 1'b1;
            c_val    <= mem_rdata;
            hold_cnt <= '0;
            state    <= FILL;
          end
        end
        // c_write stays up across the cache's eviction sweep; the first c_hit sample is stale
        FILL, WR_CACHE: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (state == WR_CACHE && hold_cnt == HW'(1))
            resp_hit <= c_hit;
          if (c_hit && hold_cnt != '0) begin
            c_write <= 1'b0;
            if (state == FILL) begin
              resp_data <= line_buf;
              state     <= RESP;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_write <= 1'b1;
              mem_addr      <= addr_q;
              mem_wdata     <= wdata_q;
              state         <= MEM_WR;
            end
          end else if (hold_cnt == HOLD_LAST) begin
            c_write  <= 1'b0;
            resp_err <= 1'b1;
            if (state == FILL)
              resp_data <= line_buf;
            state <= RESP;
          end
        end
        MEM_WR: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Outcome flags are final while in RESP, so count there
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_hits     <= '0;
      stat_misses   <= '0;
      stat_timeouts <= '0;
    end else if (state == RESP) begin
      if (resp_hit) stat_hits   <= sat_inc(stat_hits);
      else          stat_misses <= sat_inc(stat_misses);
      if (resp_err) stat_timeouts <= sat_inc(stat_timeouts);
    end
  end
`endif

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Directed bench for cache_req_ctrl; the cache and memory are emulated by hand-driven inputs.
`timescale 1ns/1ps
module tb_cache_req_ctrl;
  logic        clock, reset_n;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_hit, resp_err;
  logic [31:0] resp_data;
  logic [7:0]  c_addr;
  logic [31:0] c_val;
  logic        c_read, c_write, c_hit;
  logic [31:0] c_out_val;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_timeouts;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   n;
  logic mem_seen;

  cache_req_ctrl #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .FILL_TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit), .resp_err(resp_err),
    .c_addr(c_addr), .c_val(c_val), .c_read(c_read), .c_write(c_write),
    .c_hit(c_hit), .c_out_val(c_out_val),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_timeouts(stat_timeouts)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk32(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    chk32(tag, {24'b0, obs}, {24'b0, exp});
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    c_hit = 1'b0; c_out_val = '0; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick; tick;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_c_read", c_read, 1'b0);
    chk1("rst_c_write", c_write, 1'b0);
    chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    reset_n = 1'b1;
    tick;

    // Read hit at 0x10
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
    tick;
    chk1("t1_ready_drop", req_ready, 1'b0);
    chk1("t1_c_read", c_read, 1'b1);
    chk8("t1_c_addr", c_addr, 8'h10);
    req_valid = 1'b0; c_hit = 1'b0;
    tick;
    chk1("t1_c_read_one_cycle", c_read, 1'b0);
    c_hit = 1'b1; c_out_val = 32'hDEADBEEF;
    tick;
    chk1("t1_resp_not_early", resp_valid, 1'b0);
    c_hit = 1'b0; c_out_val = '0;
    tick;
    chk1("t1_resp_valid", resp_valid, 1'b1);
    chk32("t1_resp_data", resp_data, 32'hDEADBEEF);
    chk1("t1_resp_hit", resp_hit, 1'b1);
    chk1("t1_resp_err", resp_err, 1'b0);
    chk1("t1_ready_back", req_ready, 1'b1);
    tick;
    chk1("t1_resp_pulse", resp_valid, 1'b0);

    // Read miss at 0x20, memory handshake stalled one cycle
    req_valid = 1'b1; req_addr = 8'h20;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    chk1("t2_mem_req_valid", mem_req_valid, 1'b1);
    chk1("t2_mem_req_write", mem_req_write, 1'b0);
    chk8("t2_mem_addr", mem_addr, 8'h20);
    tick;
    chk1("t2_mem_req_held", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    tick;
    chk1("t2_mem_req_drop", mem_req_valid, 1'b0);
    mem_req_ready = 1'b0;
    tick;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick;
    chk1("t2_fill_c_write", c_write, 1'b1);
    chk32("t2_fill_c_val", c_val, 32'hCAFEF00D);
    chk8("t2_fill_c_addr", c_addr, 8'h20);
    mem_rvalid = 1'b0; c_hit = 1'b1;
    tick;
    chk1("t2_stale_hit_ignored", c_write, 1'b1);
    c_hit = 1'b0;
    tick;
    chk1("t2_c_write_sweep", c_write, 1'b1);
    c_hit = 1'b1;
    tick;
    chk1("t2_c_write_drop", c_write, 1'b0);
    c_hit = 1'b0;
    tick;
    chk1("t2_resp_valid", resp_valid, 1'b1);
    chk32("t2_resp_data", resp_data, 32'hCAFEF00D);
    chk1("t2_resp_hit", resp_hit, 1'b0);
    chk1("t2_resp_err", resp_err, 1'b0);

    // Fill timeout at 0x40 with c_hit tied low
    req_valid = 1'b1; req_addr = 8'h40; mem_req_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    tick;
    mem_req_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    tick;
    mem_rvalid = 1'b0;
    n = 0; mem_seen = 1'b0;
    while (c_write && n < 40) begin
      n++;
      tick;
      if (mem_req_valid) mem_seen = 1'b1;
    end
    chk32("t4_c_write_cycles", n, 32'd16);
    tick;
    chk1("t4_resp_valid", resp_valid, 1'b1);
    chk1("t4_resp_err", resp_err, 1'b1);
    chk1("t4_resp_hit", resp_hit, 1'b0);
    chk32("t4_resp_data", resp_data, 32'h55AA55AA);
    chk1("t4_no_mem_req", mem_seen, 1'b0);
`ifdef CACHE_STATS_EN
    chk32("t6_stat_hits", stat_hits, 32'd1);
    chk32("t6_stat_misses", stat_misses, 32'd2);
    chk32("t6_stat_timeouts", stat_timeouts, 32'd1);
`endif
    tick;

    // Write 0x30=0x1234 into a full cache; sweep holds c_hit low
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h30; req_wdata = 32'h1234;
    tick;
    chk1("t3_c_write", c_write, 1'b1);
    chk1("t3_c_read", c_read, 1'b0);
    chk32("t3_c_val", c_val, 32'h1234);
    chk8("t3_c_addr", c_addr, 8'h30);
    req_valid = 1'b0; req_write = 1'b0; c_hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk1("t3_c_write_sweep", c_write, 1'b1);
    end
    c_hit = 1'b1;
    tick;
    chk1("t3_c_write_drop", c_write, 1'b0);
    chk1("t3_mem_req_valid", mem_req_valid, 1'b1);
    chk1("t3_mem_req_write", mem_req_write, 1'b1);
    chk8("t3_mem_addr", mem_addr, 8'h30);
    chk32("t3_mem_wdata", mem_wdata, 32'h1234);
    c_hit = 1'b0; mem_req_ready = 1'b1;
    tick;
    chk1("t3_mem_req_drop", mem_req_valid, 1'b0);
    mem_req_ready = 1'b0;
    tick;
    chk1("t3_resp_valid", resp_valid, 1'b1);
    chk1("t3_resp_hit", resp_hit, 1'b0);
    chk32("t3_resp_data", resp_data, 32'h1234);
    chk1("t3_resp_err", resp_err, 1'b0);

    // Write timeout: no memory write may be issued
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h31; req_wdata = 32'h99;
    tick;
    req_valid = 1'b0; req_write = 1'b0; mem_req_ready = 1'b1;
    n = 0; mem_seen = 1'b0;
    while (!resp_valid && n < 40) begin
      tick;
      n++;
      if (mem_req_valid) mem_seen = 1'b1;
    end
    chk32("t4w_latency", n, 32'd17);
    chk1("t4w_resp_err", resp_err, 1'b1);
    chk32("t4w_resp_data", resp_data, 32'h99);
    chk1("t4w_no_mem_write", mem_seen, 1'b0);
    mem_req_ready = 1'b0;
    tick;

    // Reset while waiting for memory read data
    req_valid = 1'b1; req_addr = 8'h50;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    tick;
    chk1("t5_busy", req_ready, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk1("t5_req_ready", req_ready, 1'b1);
    chk1("t5_c_read", c_read, 1'b0);
    chk1("t5_c_write", c_write, 1'b0);
    chk1("t5_mem_req_valid", mem_req_valid, 1'b0);
    chk1("t5_resp_valid", resp_valid, 1'b0);
`ifdef CACHE_STATS_EN
    chk32("t5_stat_cleared", stat_misses, 32'd0);
`endif
    #1 reset_n = 1'b1;
    tick;
    req_valid = 1'b1; req_addr = 8'h60;
    tick;
    chk1("t5_post_c_read", c_read, 1'b1);
    req_valid = 1'b0;
    tick;
    c_hit = 1'b1; c_out_val = 32'h0BADF00D;
    tick;
    c_hit = 1'b0; c_out_val = '0;
    tick;
    chk1("t5_post_resp_valid", resp_valid, 1'b1);
    chk32("t5_post_resp_data", resp_data, 32'h0BADF00D);
    chk1("t5_post_resp_hit", resp_hit, 1'b1);
`ifdef CACHE_STATS_EN
    chk32("t5_post_stat_hits", stat_hits, 32'd1);
`endif
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
